// File: rtl/fp_accum_seq.sv
// Reduction sequencer for the pipelined fp32 adder: folds a stream of terms into one sum
// by issuing one accumulator+term add per term after the first.
module fp_accum_seq #(
    parameter int unsigned LEN_W   = 8,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [LEN_W-1:0] i_len,
    input  logic [31:0]      i_term,
    input  logic             i_term_vld,
    output logic             o_term_rdy,
    output logic [31:0]      o_add_a,
    output logic [31:0]      o_add_b,
    output logic             o_add_vld,
    input  logic [31:0]      i_add_res,
    input  logic             i_add_res_vld,
    input  logic             i_add_ovf,
    output logic [31:0]      o_sum,
    output logic             o_sum_vld,
    output logic             o_ovf,
    output logic             o_err,
    output logic             o_busy
);

    localparam int unsigned TmoW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        StIdle, StFirst, StNext, StWait, StDrain, StDone
    } state_e;

    state_e           state_q, state_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [TmoW-1:0]  tmo_q, tmo_d;
    logic [31:0]      acc_q, acc_d;
    logic [31:0]      add_a_q, add_a_d, add_b_q, add_b_d;
    logic [31:0]      sum_q, sum_d;
    logic             rdy_q, rdy_d, add_vld_q, add_vld_d, sum_vld_q, sum_vld_d;
    logic             ovf_q, ovf_d, err_q, err_d, busy_q, busy_d;
    logic             term_xfer;

    // Ready is a flop, so the handshake never depends combinationally on i_term_vld.
    assign term_xfer = i_term_vld && rdy_q;

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        tmo_d     = '0;
        acc_d     = acc_q;
        add_a_d   = add_a_q;
        add_b_d   = add_b_q;
        sum_d     = sum_q;
        ovf_d     = ovf_q;
        add_vld_d = 1'b0;
        sum_vld_d = 1'b0;
        err_d     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    rem_d = i_len;
                    ovf_d = 1'b0;
                    if (i_len == '0) begin
                        acc_d   = '0;
                        state_d = StDone;
                    end else begin
                        state_d = StFirst;
                    end
                end
            end
            StFirst: begin
                if (term_xfer) begin
                    acc_d   = i_term;
                    rem_d   = rem_q - LEN_W'(1);
                    state_d = (rem_q == LEN_W'(1)) ? StDone : StNext;
                end
            end
            StNext: begin
                if (term_xfer) begin
                    add_a_d   = acc_q;
                    add_b_d   = i_term;
                    add_vld_d = 1'b1;
                    state_d   = StWait;
                end
            end
            StWait: begin
                if (i_add_res_vld) begin
                    acc_d   = i_add_res;
                    ovf_d   = ovf_q | i_add_ovf;
                    rem_d   = rem_q - LEN_W'(1);
                    state_d = StDrain;
                end else begin
                    tmo_d = tmo_q + TmoW'(1);
                    if (tmo_d == TmoW'(TIMEOUT)) begin
                        err_d   = 1'b1;
                        state_d = StIdle;
                    end
                end
            end
            // Adder may hold valid for several cycles; only the first cycle was captured.
            StDrain: begin
                if (!i_add_res_vld) begin
                    state_d = (rem_q == '0) ? StDone : StNext;
                end
            end
            StDone: begin
                sum_d     = acc_q;
                sum_vld_d = 1'b1;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
        rdy_d  = (state_d == StFirst) || (state_d == StNext);
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            rem_q     <= '0;
            tmo_q     <= '0;
            acc_q     <= '0;
            add_a_q   <= '0;
            add_b_q   <= '0;
            sum_q     <= '0;
            rdy_q     <= 1'b0;
            add_vld_q <= 1'b0;
            sum_vld_q <= 1'b0;
            ovf_q     <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            tmo_q     <= tmo_d;
            acc_q     <= acc_d;
            add_a_q   <= add_a_d;
            add_b_q   <= add_b_d;
            sum_q     <= sum_d;
            rdy_q     <= rdy_d;
            add_vld_q <= add_vld_d;
            sum_vld_q <= sum_vld_d;
            ovf_q     <= ovf_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
        end
    end

    assign o_term_rdy = rdy_q;
    assign o_add_a    = add_a_q;
    assign o_add_b    = add_b_q;
    assign o_add_vld  = add_vld_q;
    assign o_sum      = sum_q;
    assign o_sum_vld  = sum_vld_q;
    assign o_ovf      = ovf_q;
    assign o_err      = err_q;
    assign o_busy     = busy_q;

endmodule

// File: tb/tb_fp_accum_seq.sv
// Scoreboard bench for fp_accum_seq with a behavioural pipelined-adder model
// (configurable latency, valid hold, overflow flag, or no response).
module tb_fp_accum_seq;

    localparam int unsigned LEN_W   = 8;
    localparam int unsigned TIMEOUT = 64;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             i_start = 1'b0;
    logic [LEN_W-1:0] i_len = '0;
    logic [31:0]      i_term = '0;
    logic             i_term_vld = 1'b0;
    logic             o_term_rdy;
    logic [31:0]      o_add_a, o_add_b;
    logic             o_add_vld;
    logic [31:0]      i_add_res = '0;
    logic             i_add_res_vld = 1'b0;
    logic             i_add_ovf = 1'b0;
    logic [31:0]      o_sum;
    logic             o_sum_vld, o_ovf, o_err, o_busy;

    fp_accum_seq #(.LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_len(i_len),
        .i_term(i_term), .i_term_vld(i_term_vld), .o_term_rdy(o_term_rdy),
        .o_add_a(o_add_a), .o_add_b(o_add_b), .o_add_vld(o_add_vld),
        .i_add_res(i_add_res), .i_add_res_vld(i_add_res_vld), .i_add_ovf(i_add_ovf),
        .o_sum(o_sum), .o_sum_vld(o_sum_vld), .o_ovf(o_ovf), .o_err(o_err), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic [31:0] a; logic [31:0] b;} add_t;
    typedef struct packed {logic [31:0] sum; logic ovf;} sum_t;

    int   checks = 0;
    int   errors = 0;
    add_t exp_add_q[$], obs_add_q[$];
    sum_t exp_sum_q[$], obs_sum_q[$];
    int   cyc = 0, err_cnt = 0, rdy_cnt = 0, last_add_cyc = 0, last_err_cyc = 0;

    // Adder model state
    int          mdl_lat = 3, mdl_hold = 1;
    bit          mdl_respond = 1'b1;
    logic [31:0] mdl_res_q[$];
    logic        mdl_ovf_q[$];
    int          lat_left = 0, hold_left = 0;
    logic [31:0] pend_res = '0;
    logic        pend_ovf = 1'b0;

    always @(negedge clk) begin
        if (hold_left > 0) begin
            hold_left--;
            if (hold_left == 0) begin
                i_add_res_vld = 1'b0;
                i_add_ovf     = 1'b0;
            end
        end else if (lat_left > 0) begin
            lat_left--;
            if (lat_left == 0) begin
                i_add_res     = pend_res;
                i_add_ovf     = pend_ovf;
                i_add_res_vld = 1'b1;
                hold_left     = mdl_hold;
            end
        end
        if (o_add_vld && mdl_respond && mdl_res_q.size() > 0) begin
            pend_res = mdl_res_q.pop_front();
            pend_ovf = mdl_ovf_q.pop_front();
            lat_left = mdl_lat;
        end
    end

    // Output monitor
    always @(negedge clk) begin
        cyc++;
        if (o_add_vld) begin
            obs_add_q.push_back({o_add_a, o_add_b});
            last_add_cyc = cyc;
        end
        if (o_sum_vld) obs_sum_q.push_back({o_sum, o_ovf});
        if (o_err) begin
            err_cnt++;
            last_err_cyc = cyc;
        end
        if (o_term_rdy) rdy_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish before 200000ns");
        $fatal(1);
    end

    task automatic clear_sb();
        exp_add_q.delete(); obs_add_q.delete();
        exp_sum_q.delete(); obs_sum_q.delete();
    endtask

    task automatic start_run(input int len);
        @(negedge clk);
        i_start = 1'b1;
        i_len   = LEN_W'(len);
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic drive_term(input logic [31:0] t);
        int n = 0;
        @(negedge clk);
        i_term     = t;
        i_term_vld = 1'b1;
        while (!o_term_rdy && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL term_rdy_wait: got rdy=0 want rdy=1 within 200 cycles");
        end
        @(negedge clk);
        i_term_vld = 1'b0;
        i_term     = '0;
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        while (o_busy && n < bound) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= bound) begin
            errors++;
            $display("FAIL idle_wait: got busy=1 want busy=0 within %0d cycles", bound);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({o_sum_vld, o_term_rdy, o_add_vld, o_ovf, o_err, o_busy} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b want 000000",
                     {o_sum_vld, o_term_rdy, o_add_vld, o_ovf, o_err, o_busy});
        end
        checks++;
        if ({o_sum, o_add_a, o_add_b} !== 96'h0) begin
            errors++;
            $display("FAIL reset_data: got sum=%h a=%h b=%h want 0", o_sum, o_add_a, o_add_b);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_two_terms();
        add_t ea, oa;
        sum_t es, os;
        clear_sb();
        exp_add_q.push_back({32'h40000000, 32'h40400000});
        exp_sum_q.push_back({32'h40A00000, 1'b0});
        mdl_res_q.push_back(32'h40A00000); mdl_ovf_q.push_back(1'b0);
        start_run(2);
        drive_term(32'h40000000);
        drive_term(32'h40400000);
        wait_idle(200);
        checks++;
        if (obs_add_q.size() !== exp_add_q.size()) begin
            errors++;
            $display("FAIL two_add_count: got %0d want %0d", obs_add_q.size(), exp_add_q.size());
        end
        while (exp_add_q.size() > 0 && obs_add_q.size() > 0) begin
            ea = exp_add_q.pop_front(); oa = obs_add_q.pop_front(); checks++;
            if (oa !== ea) begin
                errors++;
                $display("FAIL two_add_op: got a=%h b=%h want a=%h b=%h", oa.a, oa.b, ea.a, ea.b);
            end
        end
        checks++;
        if (obs_sum_q.size() !== exp_sum_q.size()) begin
            errors++;
            $display("FAIL two_sum_count: got %0d want %0d", obs_sum_q.size(), exp_sum_q.size());
        end
        while (exp_sum_q.size() > 0 && obs_sum_q.size() > 0) begin
            es = exp_sum_q.pop_front(); os = obs_sum_q.pop_front(); checks++;
            if (os !== es) begin
                errors++;
                $display("FAIL two_sum: got %h ovf=%b want %h ovf=%b", os.sum, os.ovf, es.sum, es.ovf);
            end
        end
        repeat (5) @(negedge clk);
        checks++;
        if (o_sum !== 32'h40A00000) begin
            errors++;
            $display("FAIL two_sum_hold: got %h want 40a00000", o_sum);
        end
    endtask

    task automatic test_three_terms();
        add_t ea, oa;
        sum_t es, os;
        clear_sb();
        exp_add_q.push_back({32'h40000000, 32'h40400000});
        exp_add_q.push_back({32'h40A00000, 32'hC0000000});
        exp_sum_q.push_back({32'h40400000, 1'b0});
        mdl_res_q.push_back(32'h40A00000); mdl_ovf_q.push_back(1'b0);
        mdl_res_q.push_back(32'h40400000); mdl_ovf_q.push_back(1'b0);
        start_run(3);
        drive_term(32'h40000000);
        drive_term(32'h40400000);
        drive_term(32'hC0000000);
        wait_idle(300);
        checks++;
        if (obs_add_q.size() !== exp_add_q.size()) begin
            errors++;
            $display("FAIL three_add_count: got %0d want %0d", obs_add_q.size(), exp_add_q.size());
        end
        while (exp_add_q.size() > 0 && obs_add_q.size() > 0) begin
            ea = exp_add_q.pop_front(); oa = obs_add_q.pop_front(); checks++;
            if (oa !== ea) begin
                errors++;
                $display("FAIL three_add_op: got a=%h b=%h want a=%h b=%h", oa.a, oa.b, ea.a, ea.b);
            end
        end
        checks++;
        if (obs_sum_q.size() !== exp_sum_q.size()) begin
            errors++;
            $display("FAIL three_sum_count: got %0d want %0d", obs_sum_q.size(), exp_sum_q.size());
        end
        while (exp_sum_q.size() > 0 && obs_sum_q.size() > 0) begin
            es = exp_sum_q.pop_front(); os = obs_sum_q.pop_front(); checks++;
            if (os !== es) begin
                errors++;
                $display("FAIL three_sum: got %h ovf=%b want %h ovf=%b", os.sum, os.ovf, es.sum, es.ovf);
            end
        end
    endtask

    task automatic test_single_and_zero();
        int n;
        clear_sb();
        start_run(1);
        drive_term(32'h42F6E979);
        wait_idle(100);
        checks++;
        if (obs_add_q.size() !== 0) begin
            errors++;
            $display("FAIL single_add_count: got %0d want 0", obs_add_q.size());
        end
        checks++;
        if (obs_sum_q.size() !== 1 || obs_sum_q[0] !== {32'h42F6E979, 1'b0}) begin
            errors++;
            $display("FAIL single_sum: got count=%0d sum=%h want count=1 sum=42f6e979",
                     obs_sum_q.size(), o_sum);
        end
        clear_sb();
        rdy_cnt = 0;
        @(negedge clk);
        i_start = 1'b1;
        i_len   = '0;
        n = 0;
        do begin
            @(negedge clk);
            i_start = 1'b0;
            n++;
        end while (!o_sum_vld && n < 10);
        checks++;
        if (n !== 2) begin
            errors++;
            $display("FAIL zero_latency: got %0d cycles want 2", n);
        end
        checks++;
        if ({o_sum, o_ovf} !== 33'h0) begin
            errors++;
            $display("FAIL zero_sum: got %h ovf=%b want 00000000 ovf=0", o_sum, o_ovf);
        end
        wait_idle(20);
        checks++;
        if (rdy_cnt !== 0) begin
            errors++;
            $display("FAIL zero_rdy: got %0d ready cycles want 0", rdy_cnt);
        end
    endtask

    task automatic test_overflow_hold();
        add_t ea, oa;
        sum_t es, os;
        clear_sb();
        mdl_hold = 4;
        exp_add_q.push_back({32'h3F800000, 32'h40000000});
        exp_add_q.push_back({32'h40400000, 32'h40400000});
        exp_sum_q.push_back({32'h40C00000, 1'b1});
        mdl_res_q.push_back(32'h40400000); mdl_ovf_q.push_back(1'b1);
        mdl_res_q.push_back(32'h40C00000); mdl_ovf_q.push_back(1'b0);
        start_run(3);
        drive_term(32'h3F800000);
        drive_term(32'h40000000);
        drive_term(32'h40400000);
        wait_idle(300);
        mdl_hold = 1;
        checks++;
        if (obs_add_q.size() !== exp_add_q.size()) begin
            errors++;
            $display("FAIL ovf_add_count: got %0d want %0d", obs_add_q.size(), exp_add_q.size());
        end
        while (exp_add_q.size() > 0 && obs_add_q.size() > 0) begin
            ea = exp_add_q.pop_front(); oa = obs_add_q.pop_front(); checks++;
            if (oa !== ea) begin
                errors++;
                $display("FAIL ovf_add_op: got a=%h b=%h want a=%h b=%h", oa.a, oa.b, ea.a, ea.b);
            end
        end
        checks++;
        if (obs_sum_q.size() !== exp_sum_q.size()) begin
            errors++;
            $display("FAIL ovf_sum_count: got %0d want %0d", obs_sum_q.size(), exp_sum_q.size());
        end
        while (exp_sum_q.size() > 0 && obs_sum_q.size() > 0) begin
            es = exp_sum_q.pop_front(); os = obs_sum_q.pop_front(); checks++;
            if (os !== es) begin
                errors++;
                $display("FAIL ovf_sum: got %h ovf=%b want %h ovf=%b", os.sum, os.ovf, es.sum, es.ovf);
            end
        end
    endtask

    task automatic test_timeout();
        sum_t es, os;
        clear_sb();
        err_cnt     = 0;
        mdl_respond = 1'b0;
        start_run(2);
        drive_term(32'h40000000);
        drive_term(32'h40400000);
        wait_idle(500);
        mdl_respond = 1'b1;
        checks++;
        if (err_cnt !== 1) begin
            errors++;
            $display("FAIL timeout_err_count: got %0d want 1", err_cnt);
        end
        checks++;
        if (last_err_cyc - last_add_cyc !== TIMEOUT) begin
            errors++;
            $display("FAIL timeout_delay: got %0d want %0d", last_err_cyc - last_add_cyc, TIMEOUT);
        end
        checks++;
        if (obs_sum_q.size() !== 0) begin
            errors++;
            $display("FAIL timeout_no_sum: got %0d sums want 0", obs_sum_q.size());
        end
        clear_sb();
        exp_sum_q.push_back({32'h40A00000, 1'b0});
        mdl_res_q.push_back(32'h40A00000); mdl_ovf_q.push_back(1'b0);
        start_run(2);
        drive_term(32'h40000000);
        drive_term(32'h40400000);
        wait_idle(200);
        checks++;
        if (obs_sum_q.size() !== exp_sum_q.size()) begin
            errors++;
            $display("FAIL recover_sum_count: got %0d want %0d", obs_sum_q.size(), exp_sum_q.size());
        end
        while (exp_sum_q.size() > 0 && obs_sum_q.size() > 0) begin
            es = exp_sum_q.pop_front(); os = obs_sum_q.pop_front(); checks++;
            if (os !== es) begin
                errors++;
                $display("FAIL recover_sum: got %h ovf=%b want %h ovf=%b", os.sum, os.ovf, es.sum, es.ovf);
            end
        end
    endtask

    task automatic test_start_busy();
        sum_t es, os;
        clear_sb();
        exp_sum_q.push_back({32'h40A00000, 1'b0});
        mdl_res_q.push_back(32'h40A00000); mdl_ovf_q.push_back(1'b0);
        start_run(2);
        start_run(0);
        drive_term(32'h40000000);
        drive_term(32'h40400000);
        start_run(0);
        wait_idle(200);
        repeat (5) @(negedge clk);
        checks++;
        if (o_busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_start_idle: got busy=%b want 0", o_busy);
        end
        checks++;
        if (obs_sum_q.size() !== exp_sum_q.size()) begin
            errors++;
            $display("FAIL busy_sum_count: got %0d want %0d", obs_sum_q.size(), exp_sum_q.size());
        end
        while (exp_sum_q.size() > 0 && obs_sum_q.size() > 0) begin
            es = exp_sum_q.pop_front(); os = obs_sum_q.pop_front(); checks++;
            if (os !== es) begin
                errors++;
                $display("FAIL busy_sum: got %h ovf=%b want %h ovf=%b", os.sum, os.ovf, es.sum, es.ovf);
            end
        end
    endtask

    task automatic test_reset_inflight();
        clear_sb();
        mdl_lat = 12;
        mdl_res_q.push_back(32'h40A00000); mdl_ovf_q.push_back(1'b1);
        start_run(2);
        drive_term(32'h40000000);
        drive_term(32'h40400000);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({o_sum_vld, o_term_rdy, o_add_vld, o_ovf, o_err, o_busy} !== 6'b0 ||
            {o_sum, o_add_a, o_add_b} !== 96'h0) begin
            errors++;
            $display("FAIL rst_wait_outputs: got flags=%b sum=%h a=%h b=%h want all 0",
                     {o_sum_vld, o_term_rdy, o_add_vld, o_ovf, o_err, o_busy}, o_sum, o_add_a, o_add_b);
        end
        repeat (20) @(negedge clk);
        mdl_lat = 3;
        checks++;
        if ({o_busy, o_ovf, o_sum} !== 34'h0 || obs_sum_q.size() !== 0) begin
            errors++;
            $display("FAIL rst_late_result: got busy=%b ovf=%b sum=%h sums=%0d want 0 0 0 0",
                     o_busy, o_ovf, o_sum, obs_sum_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_two_terms();
        test_three_terms();
        test_single_and_zero();
        test_overflow_hold();
        test_timeout();
        test_start_busy();
        test_reset_inflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp_accum_seq.md
Name: fp_accum_seq

Overview:
- Initiator-side sequencer for the pipelined fp32 adder (`i_a`/`i_b`/`i_vld` in, `o_res`/`o_res_vld`/`overflow` out).
- Accepts a stream of `i_len` IEEE-754 single-precision terms and issues one add per term after the first. Each add combines the running accumulator with the new term.
- Collects each adder result, then returns the final sum with a one-cycle valid pulse.
- Used by the matrix-multiplier datapath to reduce products into a dot-product element.

Parameters:
- `LEN_W`, 8, width of term-count input.
- `TIMEOUT`, 64, max cycles to wait for adder result before abort.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `i_start`  in  1  start a reduction; sampled only in IDLE.
- `i_len`  in  `LEN_W`  number of terms; latched with `i_start`.
- `i_term`  in  32  fp32 term.
- `i_term_vld`  in  1  term valid.
- `o_term_rdy`  out  1  sequencer ready for a term.
- `o_add_a`  out  32  to adder `i_a` (accumulator).
- `o_add_b`  out  32  to adder `i_b` (term).
- `o_add_vld`  out  1  to adder `i_vld`, 1-cycle pulse.
- `i_add_res`  in  32  from adder `o_res`.
- `i_add_res_vld`  in  1  from adder `o_res_vld`; may stay high several cycles.
- `i_add_ovf`  in  1  from adder `overflow`; sampled with the result.
- `o_sum`  out  32  final sum, held until the next `o_sum_vld`.
- `o_sum_vld`  out  1  1-cycle pulse.
- `o_ovf`  out  1  sticky OR of `i_add_ovf` over the current reduction; valid with `o_sum_vld`.
- `o_err`  out  1  1-cycle pulse on timeout abort.
- `o_busy`  out  1  high in any state except IDLE.

Behaviour:
- Reset values: all outputs 0; state IDLE; accumulator 0; remaining count 0; timeout counter 0.
- Term handshake: a term transfers when `i_term_vld && o_term_rdy` at a rising edge.
- `o_term_rdy` is high only in FIRST and NEXT. It is registered (no combinational path from `i_term_vld`).

State machine:
- IDLE: `o_busy`=0. On `i_start`, latch `i_len` into `rem`, clear `o_ovf`, then:
  - `i_len`==0: go to DONE with accumulator 0x00000000.
  - otherwise: go to FIRST.
- FIRST: on a term transfer, acc<=`i_term`, rem<=rem-1. If rem becomes 0 go to DONE, else go to NEXT. No add is issued.
- NEXT: on a term transfer:
  - register `o_add_a`<=acc and `o_add_b`<=`i_term`;
  - assert `o_add_vld` for exactly the following cycle;
  - go to WAIT.
  - `o_add_a`/`o_add_b` stay stable until the result is captured.
- WAIT: the timeout counter increments each cycle.
  - On the first cycle with `i_add_res_vld`=1: acc<=`i_add_res`, `o_ovf`<=`o_ovf` | `i_add_ovf`, rem<=rem-1, go to DRAIN.
  - If the counter reaches `TIMEOUT` without a result: pulse `o_err`, go to IDLE. No `o_sum_vld` is produced.
- DRAIN: wait until `i_add_res_vld`=0.
  - Exactly one capture per add, regardless of how long the adder holds valid.
  - Then go to DONE if rem==0, else NEXT.
  - If `i_add_res_vld` is low in the cycle after capture, leave immediately.
- DONE: `o_sum`<=acc, `o_sum_vld`=1 for one cycle, go to IDLE. A new `i_start` is accepted from the following cycle.
- `i_start` while busy: ignored.
- `i_add_res_vld` outside WAIT: ignored.
- `rst` at any point: return to IDLE within one cycle with all outputs 0. An in-flight adder result arriving after reset is ignored.
- No fp arithmetic is done locally; the only values are pass-through/bitwise. `rem` is decremented only, with no wrap (only reached via checked states).

Test Plan:
- `i_len`=2, terms 0x40000000, 0x40400000; adder model latency 3, returns 0x40A00000 → exactly one `o_add_vld` with a=0x40000000, b=0x40400000; `o_sum`=0x40A00000, `o_sum_vld` 1 cycle, `o_ovf`=0.
- `i_len`=3, terms 2.0, 3.0, -2.0 (0xC0000000); model returns 0x40A00000 then 0x40400000 → two adds, second with a=0x40A00000; `o_sum`=0x40400000.
- `i_len`=1, term 0x42F6E979 → no `o_add_vld`; `o_sum`=0x42F6E979. `i_len`=0 → `o_sum`=0x00000000, pulse 2 cycles after `i_start`, no `o_term_rdy`.
- Model holds `o_res_vld` 4 cycles with `overflow`=1 on the first add of `i_len`=3 → one capture per add, exactly 2 adds total, `o_ovf`=1 at `o_sum_vld`.
- Model never responds, `TIMEOUT`=64 → `o_err` pulse 64 cycles after entering WAIT, back to IDLE, no `o_sum_vld`; a subsequent `i_len`=2 run completes correctly.
- `rst` asserted in WAIT, then the late result arrives → outputs 0, state IDLE, late result ignored; `i_start` asserted during busy is ignored.
